// File: rtl/patient_input_scanner_if.sv
// Event stream handshake between the patient input scanner and its consumer.
// The scanner is the master; the consumer pulls events with evt_ready.
interface patient_input_scanner_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;

  modport master (
    output evt_valid,
    output evt_code,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    output evt_ready
  );
endinterface

// File: rtl/patient_input_scanner.sv
// N-line scanner for patient buttons and foot pedals: scan pulses, per-line
// frame deserialisers, connection tracking and a press/release event FIFO.
module patient_input_scanner #(
  parameter int NUM_LINES    = 2,
  parameter int SCAN_PERIOD  = 1000,
  parameter int BUTT_PULSE   = 3,
  parameter int PEDAL_PULSE  = 8,
  parameter int READ_WINDOW  = 70,
  parameter int BIT_DELAY    = 3,
  parameter int DISCON_SCANS = 4,
  parameter int EVT_DEPTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LINES-1:0] in_line,
  output logic [NUM_LINES-1:0] out_line,
  output logic                 scan_is_butt,
  patient_input_scanner_if.master evt,
  output logic                 evt_ovf,
  input  logic                 ovf_clr,
  output logic [NUM_LINES-1:0] line_conn,
  output logic [NUM_LINES-1:0] line_is_butt,
  output logic [1:0]           butt_state
);

  localparam int CW  = $clog2(SCAN_PERIOD + 1);
  localparam int PMX = (BUTT_PULSE > PEDAL_PULSE) ? BUTT_PULSE : PEDAL_PULSE;
  localparam int PW  = $clog2(PMX + 1);
  localparam int WW  = $clog2(READ_WINDOW + 1);
  localparam int TW  = $clog2(BIT_DELAY + 1);
  localparam int MW  = $clog2(DISCON_SCANS + 1);
  localparam int LW  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int AW  = $clog2(EVT_DEPTH);

  logic [CW-1:0] cnt;
  logic [PW-1:0] pcnt;
  logic [WW-1:0] wcnt;
  logic          pulse;
  logic          pulse_end;
  logic          win_open;
  logic          win_close;

  assign pulse_end = pulse && (pcnt == '0);
  assign win_open  = (wcnt != '0);
  assign win_close = (wcnt == WW'(1));
  assign out_line  = {NUM_LINES{~pulse}};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= CW'(SCAN_PERIOD - 1);
      pcnt         <= '0;
      wcnt         <= '0;
      pulse        <= 1'b0;
      scan_is_butt <= 1'b0;
    end else begin
      cnt <= (cnt == '0) ? CW'(SCAN_PERIOD - 1) : cnt - 1'b1;
      if (cnt == '0) begin
        scan_is_butt <= ~scan_is_butt;
        pulse        <= 1'b1;
        pcnt         <= scan_is_butt ? PW'(PEDAL_PULSE - 1)
                                     : PW'(BUTT_PULSE - 1);
      end else if (pulse_end) begin
        pulse <= 1'b0;
      end else if (pulse) begin
        pcnt <= pcnt - 1'b1;
      end
      // Window opens on the rising edge of the scan output.
      if (pulse_end && cnt != '0)
        wcnt <= WW'(READ_WINDOW);
      else if (win_open)
        wcnt <= wcnt - 1'b1;
    end
  end

  logic [NUM_LINES-1:0] s1, s2, s3;
  logic [NUM_LINES-1:0] busy, frdy, got, valid;
  logic [TW-1:0]        tmr  [NUM_LINES];
  logic [2:0]           nb   [NUM_LINES];
  logic [4:0]           sh   [NUM_LINES];
  logic [4:0]           fr   [NUM_LINES];
  logic [2:0]           state[NUM_LINES];
  logic [2:0]           pend [NUM_LINES];
  logic [2:0]           mask [NUM_LINES];
  logic [2:0]           clr  [NUM_LINES];
  logic [MW-1:0]        miss [NUM_LINES];
  logic [2:0]           chg;

  always_comb begin
    chg   = '0;
    valid = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      valid[i] = frdy[i] & ~fr[i][4];
      chg = ((fr[i][3] != line_is_butt[i]) ? 3'b111 : state[i])
            ^ fr[i][2:0];
      mask[i] = '0;
      if (valid[i])
        mask[i] = fr[i][3] ? {1'b0, chg[1:0]} : chg;
    end
  end

  logic          push;
  logic [LW-1:0] sel;
  logic [1:0]    sb;
  logic [5:0]    id;
  logic [7:0]    code;

  always_comb begin
    push = 1'b0;
    sel  = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (pend[i] != '0) begin
        push = 1'b1;
        sel  = LW'(i);
      end
    end
    if (pend[sel][0])      sb = 2'd0;
    else if (pend[sel][1]) sb = 2'd1;
    else                   sb = 2'd2;
    id   = (line_is_butt[sel] ? 6'd32 : 6'd36) + {4'd0, sb};
    code = {state[sel][sb] ? 2'b10 : 2'b01, id};
    for (int i = 0; i < NUM_LINES; i++)
      clr[i] = (push && sel == LW'(i)) ? (3'b001 << sb) : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1           <= '1;
      s2           <= '1;
      s3           <= '1;
      busy         <= '0;
      frdy         <= '0;
      got          <= '0;
      line_conn    <= '0;
      line_is_butt <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        tmr[i]   <= '0;
        nb[i]    <= '0;
        sh[i]    <= '0;
        fr[i]    <= '0;
        state[i] <= 3'b111;
        pend[i]  <= '0;
        miss[i]  <= '0;
      end
    end else begin
      s1   <= in_line;
      s2   <= s1;
      s3   <= s2;
      frdy <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        if (busy[i]) begin
          if (tmr[i] == '0) begin
            busy[i] <= 1'b0;
            sh[i]   <= {sh[i][3:0], s2[i]};
            if (nb[i] == 3'd4) begin
              nb[i]   <= '0;
              frdy[i] <= 1'b1;
              fr[i]   <= {sh[i][3:0], s2[i]};
            end else begin
              nb[i] <= nb[i] + 1'b1;
            end
          end else begin
            tmr[i] <= tmr[i] - 1'b1;
          end
        end else if (win_open && s3[i] && !s2[i]) begin
          busy[i] <= 1'b1;
          tmr[i]  <= TW'(BIT_DELAY - 1);
        end
        if (win_close) begin
          busy[i] <= 1'b0;
          nb[i]   <= '0;
        end
        pend[i] <= (pend[i] & ~clr[i]) | mask[i];
        if (valid[i]) begin
          line_conn[i]    <= 1'b1;
          line_is_butt[i] <= fr[i][3];
          state[i]        <= fr[i][2:0];
          miss[i]         <= '0;
          got[i]          <= 1'b1;
        end
        if (pulse_end) begin
          got[i] <= 1'b0;
        end else if (win_close && !got[i] && !valid[i]) begin
          if (miss[i] >= MW'(DISCON_SCANS - 1)) begin
            line_conn[i] <= 1'b0;
            state[i]     <= 3'b111;
            pend[i]      <= '0;
          end else begin
            miss[i] <= miss[i] + 1'b1;
          end
        end
      end
    end
  end

  logic [1:0] bs;

  always_comb begin
    bs = '0;
    for (int i = 0; i < NUM_LINES; i++)
      if (line_conn[i] && line_is_butt[i])
        bs = bs | ~state[i][1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) butt_state <= '0;
    else     butt_state <= bs;
  end

  logic [7:0] mem [EVT_DEPTH];
  logic [AW:0] wp, rp;
  logic        full, empty, pop, wr;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop   = ~empty & evt.evt_ready;
  assign wr    = push & (~full | pop);

  assign evt.evt_valid = ~empty;
  assign evt.evt_code  = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp      <= '0;
      rp      <= '0;
      evt_ovf <= 1'b0;
      for (int i = 0; i < EVT_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wp[AW-1:0]] <= code;
        wp              <= wp + 1'b1;
      end
      if (pop)
        rp <= rp + 1'b1;
      // A fresh drop outranks a simultaneous clear.
      if (push && full && !pop)
        evt_ovf <= 1'b1;
      else if (ovf_clr)
        evt_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_patient_input_scanner.sv
// Bench for patient_input_scanner: scan timing, frame vectors, overflow,
// disconnect and reset behaviour against an event scoreboard.
module tb_patient_input_scanner;
  localparam int NL = 2;
  localparam int SP = 1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NL-1:0] in_line = '1;
  logic [NL-1:0] out_line;
  logic          scan_is_butt;
  logic          evt_ovf;
  logic          ovf_clr = 1'b0;
  logic [NL-1:0] line_conn;
  logic [NL-1:0] line_is_butt;
  logic [1:0]    butt_state;

  patient_input_scanner_if bus ();

  patient_input_scanner #(
    .NUM_LINES(NL),
    .SCAN_PERIOD(SP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_line(in_line),
    .out_line(out_line),
    .scan_is_butt(scan_is_butt),
    .evt(bus),
    .evt_ovf(evt_ovf),
    .ovf_clr(ovf_clr),
    .line_conn(line_conn),
    .line_is_butt(line_is_butt),
    .butt_state(butt_state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] q[$];
  logic [7:0] exp_e;

  typedef struct {
    logic [4:0] f0;
    bit         v0;
    logic [4:0] f1;
    bit         v1;
    logic [1:0] conn;
    logic [1:0] lib;
    logic [1:0] bs;
  } vec_t;

  vec_t tbl[6];
  logic [2:0] m_state[NL];
  bit         m_butt[NL];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.evt_valid && bus.evt_ready) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL evt_unexpected: got %02h want none", bus.evt_code);
      end else begin
        exp_e = q.pop_front();
        if (bus.evt_code !== exp_e) begin
          fails++;
          $display("FAIL evt_code: got %02h want %02h",
                   bus.evt_code, exp_e);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_clear();
    for (int l = 0; l < NL; l++) begin
      m_state[l] = 3'b111;
      m_butt[l]  = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    in_line = '1;
    step(3);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_out_line"}, out_line, 2'b11);
    chk({tag, "_scan_is_butt"}, scan_is_butt, 0);
    chk({tag, "_evt_valid"}, bus.evt_valid, 0);
    chk({tag, "_evt_code"}, bus.evt_code, 0);
    chk({tag, "_evt_ovf"}, evt_ovf, 0);
    chk({tag, "_line_conn"}, line_conn, 0);
    chk({tag, "_line_is_butt"}, line_is_butt, 0);
    chk({tag, "_butt_state"}, butt_state, 0);
  endtask

  task automatic model(input int l, input logic [4:0] f, input bit v);
    logic [2:0] prev;
    if (v && !f[4]) begin
      prev = (f[3] != m_butt[l]) ? 3'b111 : m_state[l];
      for (int b = 0; b < (f[3] ? 2 : 3); b++)
        if (prev[b] != f[b])
          q.push_back({f[b] ? 2'b10 : 2'b01,
                       f[3] ? 6'(32 + b) : 6'(36 + b)});
      m_state[l] = f[2:0];
      m_butt[l]  = f[3];
    end
  endtask

  task automatic wait_rise();
    bit low = 0;
    bit ok  = 0;
    for (int c = 0; c < 2 * SP + 20; c++) begin
      step(1);
      if (out_line[0] == 1'b0) low = 1;
      else if (low) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL wait_rise: got timeout want scan pulse");
    end
  endtask

  task automatic drive_bits(input logic [4:0] f0, input bit v0,
                            input logic [4:0] f1, input bit v1);
    for (int b = 4; b >= 0; b--) begin
      for (int c = 0; c < 10; c++) begin
        in_line[0] = !(v0 && (c == 0 || (c < 5 && !f0[b])));
        in_line[1] = !(v1 && (c == 0 || (c < 5 && !f1[b])));
        step(1);
      end
    end
    in_line = '1;
  endtask

  task automatic send(input logic [4:0] f0, input bit v0,
                      input logic [4:0] f1, input bit v1);
    wait_rise();
    step(5);
    drive_bits(f0, v0, f1, v1);
    step(40);
  endtask

  int  starts[2];
  int  lens[2];
  bit  modes[2];
  int  nfall;
  bit  prev_hi;
  bit  evs;
  bit  ok;

  initial begin
    bus.evt_ready = 1'b1;
    tbl[0] = '{5'b01110, 1'b1, 5'b00000, 1'b0, 2'b01, 2'b01, 2'b01};
    tbl[1] = '{5'b00000, 1'b1, 5'b00000, 1'b1, 2'b11, 2'b00, 2'b00};
    tbl[2] = '{5'b00101, 1'b1, 5'b00000, 1'b1, 2'b11, 2'b00, 2'b00};
    tbl[3] = '{5'b01100, 1'b1, 5'b01101, 1'b1, 2'b11, 2'b11, 2'b11};
    tbl[4] = '{5'b11111, 1'b1, 5'b01111, 1'b1, 2'b11, 2'b11, 2'b11};
    tbl[5] = '{5'b01110, 1'b1, 5'b00011, 1'b1, 2'b11, 2'b01, 2'b01};

    // T1: scan pulse timing and mode alternation
    do_reset();
    reset_vals("rst");
    nfall   = 0;
    prev_hi = 1;
    evs     = 0;
    lens    = '{0, 0};
    starts  = '{-1, -1};
    for (int t = 0; t < 2 * SP + 20; t++) begin
      step(1);
      if (bus.evt_valid) evs = 1;
      if (out_line != 2'b11) begin
        if (prev_hi) begin
          if (nfall < 2) begin
            starts[nfall] = t;
            modes[nfall]  = scan_is_butt;
          end
          nfall++;
        end
        if (nfall >= 1 && nfall <= 2) lens[nfall-1]++;
      end
      prev_hi = (out_line == 2'b11);
    end
    chk("t1_nfall", nfall, 2);
    chk("t1_start0", starts[0], SP - 1);
    chk("t1_len0", lens[0], 3);
    chk("t1_mode0", modes[0], 1);
    chk("t1_start1", starts[1], 2 * SP - 1);
    chk("t1_len1", lens[1], 8);
    chk("t1_mode1", modes[1], 0);
    chk("t1_no_evt", evs, 0);

    // T2, T3, start-bit rejection and type changes
    for (int v = 0; v < 6; v++) begin
      model(0, tbl[v].f0, tbl[v].v0);
      model(1, tbl[v].f1, tbl[v].v1);
      send(tbl[v].f0, tbl[v].v0, tbl[v].f1, tbl[v].v1);
      chk($sformatf("v%0d_conn", v), line_conn, tbl[v].conn);
      chk($sformatf("v%0d_lib", v), line_is_butt, tbl[v].lib);
      chk($sformatf("v%0d_bs", v), butt_state, tbl[v].bs);
      chk($sformatf("v%0d_drained", v), q.size(), 0);
    end

    // Edges that arrive after the window has closed
    wait_rise();
    step(72);
    drive_bits(5'b00000, 1'b0, 5'b01000, 1'b1);
    step(20);
    chk("late_lib", line_is_butt, 2'b01);
    chk("late_bs", butt_state, 2'b01);
    chk("late_q", q.size(), 0);

    // Reset in the middle of a frame
    wait_rise();
    step(5);
    for (int b = 0; b < 2; b++) begin
      in_line[0] = 1'b0;
      step(5);
      in_line[0] = 1'b1;
      step(5);
    end
    rst = 1'b1;
    step(1);
    reset_vals("midrst");
    rst = 1'b0;
    model_clear();

    // T5: connected button goes silent
    model(0, 5'b01110, 1'b1);
    send(5'b01110, 1'b1, 5'b00000, 1'b0);
    chk("t5_conn", line_conn[0], 1);
    chk("t5_bs", butt_state, 2'b01);
    for (int s = 1; s <= 4; s++) begin
      wait_rise();
      step(75);
      chk($sformatf("t5_conn_s%0d", s), line_conn[0], (s < 4) ? 1 : 0);
    end
    chk("t5_bs_off", butt_state, 2'b00);
    chk("t5_q", q.size(), 0);

    // T4: overflow with consumer stalled
    do_reset();
    bus.evt_ready = 1'b0;
    model(0, 5'b00000, 1'b1);
    model(1, 5'b00000, 1'b1);
    send(5'b00000, 1'b1, 5'b00000, 1'b1);
    chk("t4_no_ovf_yet", evt_ovf, 0);
    model(0, 5'b00111, 1'b1);
    exp_e = q.pop_back();
    chk("t4_dropped_code", exp_e, 8'hA6);
    send(5'b00111, 1'b1, 5'b00000, 1'b0);
    chk("t4_ovf", evt_ovf, 1);
    chk("t4_valid", bus.evt_valid, 1);
    chk("t4_head", bus.evt_code, 8'h64);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("t4_ovf_clr", evt_ovf, 0);
    bus.evt_ready = 1'b1;
    step(20);
    chk("t4_q", q.size(), 0);
    chk("t4_empty", bus.evt_valid, 0);

    // Reset while a scan pulse is low
    ok = 0;
    for (int c = 0; c < 2 * SP + 20; c++) begin
      step(1);
      if (out_line == 2'b00) begin
        ok = 1;
        break;
      end
    end
    chk("pulse_seen", ok, 1);
    rst = 1'b1;
    step(1);
    chk("pulse_rst_out", out_line, 2'b11);
    rst = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
